// File: rtl/uart_frame_rx.sv
// 16x-oversampled UART receiver feeding a frame assembler that splits the byte
// stream on a three-0xFF terminator and latches each frame in a readable buffer.
module uart_frame_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600,
  parameter int MAX_LEN  = 16
) (
  input  logic       RST_clk,
  input  logic       RST_n,
  input  logic       uart_rx_data,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       rx_busy,
  output logic       frame_valid,
  output logic       frame_err,
  output logic [5:0] frame_len,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam int DIV_RAW  = CLK_FREQ / (BAUD * 16);
  localparam int TICK_DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          sync1_q, sync2_q, rxPrev_q;
  logic          fallEdge, tick;
  state_t        state_q;
  logic [DW-1:0] divCnt_q;
  logic [3:0]    tickCnt_q;
  logic [2:0]    bitIdx_q;
  logic [7:0]    shift_q;
  logic [7:0]    rxByte_q;
  logic          rxByteValid_q, busy_q, stopErr_q;

  logic [7:0] wBuf_q [MAX_LEN];
  logic [7:0] wBuf_d [MAX_LEN];
  logic [7:0] oBuf_q [MAX_LEN];
  logic [7:0] oBuf_d [MAX_LEN];
  logic [5:0] cnt_q, cnt_d, frameLen_q, frameLen_d;
  logic [1:0] ffPend_q, ffPend_d;
  logic       drop_q, drop_d;
  logic       frameValid_q, frameValid_d, frameErr_q, frameErr_d;

  always_ff @(posedge RST_clk or negedge RST_n) begin
    if (!RST_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      sync1_q  <= uart_rx_data;
      sync2_q  <= sync1_q;
      rxPrev_q <= sync2_q;
    end
  end

  assign fallEdge = rxPrev_q & ~sync2_q;
  assign tick     = (divCnt_q == DW'(TICK_DIV - 1));

  // The IDLE edge restart overrides the free-running divider so the first
  // tick lands a whole tick period after the detected start edge.
  always_ff @(posedge RST_clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q       <= IDLE;
      divCnt_q      <= '0;
      tickCnt_q     <= '0;
      bitIdx_q      <= '0;
      shift_q       <= '0;
      rxByte_q      <= '0;
      rxByteValid_q <= 1'b0;
      busy_q        <= 1'b0;
      stopErr_q     <= 1'b0;
    end else begin
      rxByteValid_q <= 1'b0;
      stopErr_q     <= 1'b0;
      divCnt_q      <= tick ? '0 : divCnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (fallEdge) begin
            state_q   <= START;
            divCnt_q  <= '0;
            tickCnt_q <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tickCnt_q == 4'd7) begin
              tickCnt_q <= '0;
              bitIdx_q  <= '0;
              if (!sync2_q) begin
                state_q <= DATA;
                busy_q  <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              tickCnt_q <= tickCnt_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tickCnt_q == 4'd15) begin
              tickCnt_q <= '0;
              shift_q   <= {sync2_q, shift_q[7:1]};
              if (bitIdx_q == 3'd7) state_q <= STOP;
              else bitIdx_q <= bitIdx_q + 3'd1;
            end else begin
              tickCnt_q <= tickCnt_q + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tickCnt_q == 4'd15) begin
              tickCnt_q <= '0;
              busy_q    <= 1'b0;
              state_q   <= IDLE;
              if (sync2_q) begin
                rxByte_q      <= shift_q;
                rxByteValid_q <= 1'b1;
              end else begin
                stopErr_q <= 1'b1;
              end
            end else begin
              tickCnt_q <= tickCnt_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // stopErr_q and rxByteValid_q are mutually exclusive, so frame_valid and
  // frame_err can never be raised together.
  always_comb begin
    wBuf_d       = wBuf_q;
    oBuf_d       = oBuf_q;
    cnt_d        = cnt_q;
    frameLen_d   = frameLen_q;
    ffPend_d     = ffPend_q;
    drop_d       = drop_q;
    frameValid_d = 1'b0;
    frameErr_d   = 1'b0;
    if (stopErr_q) begin
      cnt_d      = '0;
      ffPend_d   = '0;
      drop_d     = 1'b0;
      frameErr_d = 1'b1;
    end else if (rxByteValid_q) begin
      if (rxByte_q == 8'hFF) begin
        if (ffPend_q == 2'd2) begin
          ffPend_d = '0;
          cnt_d    = '0;
          drop_d   = 1'b0;
          if (drop_q) begin
            frameErr_d = 1'b1;
          end else begin
            frameValid_d = 1'b1;
            frameLen_d   = cnt_q;
            oBuf_d       = wBuf_q;
          end
        end else begin
          ffPend_d = ffPend_q + 2'd1;
        end
      end else if (ffPend_q != 2'd0) begin
        frameErr_d = 1'b1;
        ffPend_d   = '0;
        drop_d     = 1'b0;
        wBuf_d[0]  = rxByte_q;
        cnt_d      = 6'd1;
      end else if (!drop_q) begin
        if (cnt_q == 6'(MAX_LEN)) begin
          drop_d = 1'b1;
        end else begin
          wBuf_d[cnt_q[AW-1:0]] = rxByte_q;
          cnt_d = cnt_q + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge RST_clk or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        wBuf_q[i] <= '0;
        oBuf_q[i] <= '0;
      end
      cnt_q        <= '0;
      frameLen_q   <= '0;
      ffPend_q     <= '0;
      drop_q       <= 1'b0;
      frameValid_q <= 1'b0;
      frameErr_q   <= 1'b0;
    end else begin
      wBuf_q       <= wBuf_d;
      oBuf_q       <= oBuf_d;
      cnt_q        <= cnt_d;
      frameLen_q   <= frameLen_d;
      ffPend_q     <= ffPend_d;
      drop_q       <= drop_d;
      frameValid_q <= frameValid_d;
      frameErr_q   <= frameErr_d;
    end
  end

  assign rx_byte       = rxByte_q;
  assign rx_byte_valid = rxByteValid_q;
  assign rx_busy       = busy_q;
  assign frame_valid   = frameValid_q;
  assign frame_err     = frameErr_q;
  assign frame_len     = frameLen_q;
  assign rd_data       = ({1'b0, rd_addr} < frameLen_q) ? oBuf_q[rd_addr[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: 16 clocks per bit, frames built from
// hand-chosen byte sequences with expected lengths and contents.
module tb_uart_frame_rx;

  logic       RST_clk = 1'b0;
  logic       RST_n;
  logic       uart_rx_data;
  logic [7:0] rx_byte;
  logic       rx_byte_valid, rx_busy, frame_valid, frame_err;
  logic [5:0] frame_len;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;

  int checkCount = 0;
  int passCount  = 0;
  int rxvTotal   = 0;
  int fvTotal    = 0;
  int feTotal    = 0;
  int busyTotal  = 0;
  int bothTotal  = 0;

  uart_frame_rx #(.CLK_FREQ(1600000), .BAUD(100000), .MAX_LEN(16)) dut (
    .RST_clk(RST_clk), .RST_n(RST_n), .uart_rx_data(uart_rx_data),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .rx_busy(rx_busy),
    .frame_valid(frame_valid), .frame_err(frame_err), .frame_len(frame_len),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 RST_clk = ~RST_clk;

  // Pulse counters sampled on the falling edge, away from register updates.
  always @(negedge RST_clk) begin
    if (rx_byte_valid) rxvTotal++;
    if (frame_valid) fvTotal++;
    if (frame_err) feTotal++;
    if (rx_busy) busyTotal++;
    if (frame_valid && frame_err) bothTotal++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge RST_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stopHigh);
    uart_rx_data = 1'b0;
    wait_clks(16);
    for (int i = 0; i < 8; i++) begin
      uart_rx_data = b[i];
      wait_clks(16);
    end
    uart_rx_data = stopHigh;
    wait_clks(16);
    uart_rx_data = 1'b1;
  endtask

  task automatic send_term();
    for (int i = 0; i < 3; i++) send_byte(8'hFF, 1'b1);
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    uart_rx_data = 1'b1;
    rd_addr = 5'd0;
    wait_clks(5);
    checkCount++; if (rx_byte !== 8'h00) $display("[TB] FAIL reset_rx_byte: got %h expected 00", rx_byte); else passCount++;
    checkCount++; if (rx_byte_valid !== 1'b0) $display("[TB] FAIL reset_rx_byte_valid: got %b expected 0", rx_byte_valid); else passCount++;
    checkCount++; if (rx_busy !== 1'b0) $display("[TB] FAIL reset_rx_busy: got %b expected 0", rx_busy); else passCount++;
    checkCount++; if (frame_valid !== 1'b0) $display("[TB] FAIL reset_frame_valid: got %b expected 0", frame_valid); else passCount++;
    checkCount++; if (frame_err !== 1'b0) $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); else passCount++;
    checkCount++; if (frame_len !== 6'd0) $display("[TB] FAIL reset_frame_len: got %0d expected 0", frame_len); else passCount++;
    checkCount++; if (rd_data !== 8'h00) $display("[TB] FAIL reset_rd_data: got %h expected 00", rd_data); else passCount++;
    RST_n = 1'b1;
    wait_clks(5);
  endtask

  task automatic test_basic_frame();
    int rxv0, fv0, fe0;
    rxv0 = rxvTotal; fv0 = fvTotal; fe0 = feTotal;
    send_byte(8'h71, 1'b1);
    send_byte(8'h05, 1'b1);
    send_term();
    wait_clks(20);
    checkCount++; if (rxvTotal - rxv0 !== 5) $display("[TB] FAIL basic_rxv_count: got %0d expected 5", rxvTotal - rxv0); else passCount++;
    checkCount++; if (fvTotal - fv0 !== 1) $display("[TB] FAIL basic_fv_count: got %0d expected 1", fvTotal - fv0); else passCount++;
    checkCount++; if (feTotal - fe0 !== 0) $display("[TB] FAIL basic_fe_count: got %0d expected 0", feTotal - fe0); else passCount++;
    checkCount++; if (frame_len !== 6'd2) $display("[TB] FAIL basic_len: got %0d expected 2", frame_len); else passCount++;
    checkCount++; if (rx_byte !== 8'hFF) $display("[TB] FAIL basic_rx_byte: got %h expected ff", rx_byte); else passCount++;
    rd_addr = 5'd0; #1;
    checkCount++; if (rd_data !== 8'h71) $display("[TB] FAIL basic_rd0: got %h expected 71", rd_data); else passCount++;
    rd_addr = 5'd1; #1;
    checkCount++; if (rd_data !== 8'h05) $display("[TB] FAIL basic_rd1: got %h expected 05", rd_data); else passCount++;
    rd_addr = 5'd2; #1;
    checkCount++; if (rd_data !== 8'h00) $display("[TB] FAIL basic_rd2: got %h expected 00", rd_data); else passCount++;
  endtask

  task automatic test_glitch();
    int rxv0, fv0, fe0, busy0;
    rxv0 = rxvTotal; fv0 = fvTotal; fe0 = feTotal; busy0 = busyTotal;
    uart_rx_data = 1'b0;
    wait_clks(4);
    uart_rx_data = 1'b1;
    wait_clks(60);
    checkCount++; if (busyTotal - busy0 !== 0) $display("[TB] FAIL glitch_busy: got %0d expected 0", busyTotal - busy0); else passCount++;
    checkCount++; if (rxvTotal - rxv0 !== 0) $display("[TB] FAIL glitch_rxv: got %0d expected 0", rxvTotal - rxv0); else passCount++;
    checkCount++; if ((fvTotal - fv0) + (feTotal - fe0) !== 0) $display("[TB] FAIL glitch_frame_pulses: got %0d expected 0", (fvTotal - fv0) + (feTotal - fe0)); else passCount++;
  endtask

  task automatic test_stop_error();
    int rxv0, fe0;
    rxv0 = rxvTotal; fe0 = feTotal;
    send_byte(8'h41, 1'b0);
    wait_clks(30);
    checkCount++; if (feTotal - fe0 !== 1) $display("[TB] FAIL stop_fe_count: got %0d expected 1", feTotal - fe0); else passCount++;
    checkCount++; if (rxvTotal - rxv0 !== 0) $display("[TB] FAIL stop_rxv_count: got %0d expected 0", rxvTotal - rxv0); else passCount++;
    checkCount++; if (rx_byte !== 8'hFF) $display("[TB] FAIL stop_rx_byte: got %h expected ff", rx_byte); else passCount++;
    checkCount++; if (frame_len !== 6'd2) $display("[TB] FAIL stop_len_kept: got %0d expected 2", frame_len); else passCount++;
  endtask

  task automatic test_pending_ff();
    int fv0, fe0;
    fv0 = fvTotal; fe0 = feTotal;
    send_byte(8'h11, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h22, 1'b1);
    send_term();
    wait_clks(20);
    checkCount++; if (feTotal - fe0 !== 1) $display("[TB] FAIL pend_fe_count: got %0d expected 1", feTotal - fe0); else passCount++;
    checkCount++; if (fvTotal - fv0 !== 1) $display("[TB] FAIL pend_fv_count: got %0d expected 1", fvTotal - fv0); else passCount++;
    checkCount++; if (frame_len !== 6'd1) $display("[TB] FAIL pend_len: got %0d expected 1", frame_len); else passCount++;
    rd_addr = 5'd0; #1;
    checkCount++; if (rd_data !== 8'h22) $display("[TB] FAIL pend_rd0: got %h expected 22", rd_data); else passCount++;
    rd_addr = 5'd1; #1;
    checkCount++; if (rd_data !== 8'h00) $display("[TB] FAIL pend_rd1: got %h expected 00", rd_data); else passCount++;
  endtask

  task automatic test_overflow();
    int fv0, fe0;
    fv0 = fvTotal; fe0 = feTotal;
    for (int i = 1; i <= 17; i++) send_byte(8'(i), 1'b1);
    send_term();
    wait_clks(20);
    checkCount++; if (feTotal - fe0 !== 1) $display("[TB] FAIL ovf_fe_count: got %0d expected 1", feTotal - fe0); else passCount++;
    checkCount++; if (fvTotal - fv0 !== 0) $display("[TB] FAIL ovf_fv_count: got %0d expected 0", fvTotal - fv0); else passCount++;
    checkCount++; if (frame_len !== 6'd1) $display("[TB] FAIL ovf_len_kept: got %0d expected 1", frame_len); else passCount++;
    rd_addr = 5'd0; #1;
    checkCount++; if (rd_data !== 8'h22) $display("[TB] FAIL ovf_rd0_kept: got %h expected 22", rd_data); else passCount++;
  endtask

  task automatic test_max_len();
    int fv0, fe0;
    fv0 = fvTotal; fe0 = feTotal;
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), 1'b1);
    send_term();
    wait_clks(20);
    checkCount++; if (fvTotal - fv0 !== 1) $display("[TB] FAIL max_fv_count: got %0d expected 1", fvTotal - fv0); else passCount++;
    checkCount++; if (feTotal - fe0 !== 0) $display("[TB] FAIL max_fe_count: got %0d expected 0", feTotal - fe0); else passCount++;
    checkCount++; if (frame_len !== 6'd16) $display("[TB] FAIL max_len: got %0d expected 16", frame_len); else passCount++;
    rd_addr = 5'd15; #1;
    checkCount++; if (rd_data !== 8'h1F) $display("[TB] FAIL max_rd15: got %h expected 1f", rd_data); else passCount++;
    rd_addr = 5'd16; #1;
    checkCount++; if (rd_data !== 8'h00) $display("[TB] FAIL max_rd16: got %h expected 00", rd_data); else passCount++;
  endtask

  task automatic test_reset_mid();
    int rxv0, fv0, fe0;
    send_byte(8'h33, 1'b1);
    rxv0 = rxvTotal; fv0 = fvTotal; fe0 = feTotal;
    uart_rx_data = 1'b0;
    wait_clks(16);
    for (int i = 0; i < 4; i++) begin
      uart_rx_data = 1'(8'h44 >> i);
      wait_clks(16);
    end
    uart_rx_data = 1'b0;
    wait_clks(8);
    RST_n = 1'b0;
    wait_clks(5);
    checkCount++; if (frame_len !== 6'd0) $display("[TB] FAIL rstmid_len_in_reset: got %0d expected 0", frame_len); else passCount++;
    checkCount++; if (rx_busy !== 1'b0) $display("[TB] FAIL rstmid_busy_in_reset: got %b expected 0", rx_busy); else passCount++;
    uart_rx_data = 1'b1;
    RST_n = 1'b1;
    wait_clks(40);
    checkCount++; if ((rxvTotal - rxv0) + (fvTotal - fv0) + (feTotal - fe0) !== 0) $display("[TB] FAIL rstmid_no_pulse: got %0d expected 0", (rxvTotal - rxv0) + (fvTotal - fv0) + (feTotal - fe0)); else passCount++;
    send_term();
    wait_clks(20);
    checkCount++; if (fvTotal - fv0 !== 1) $display("[TB] FAIL rstmid_fv_count: got %0d expected 1", fvTotal - fv0); else passCount++;
    checkCount++; if (feTotal - fe0 !== 0) $display("[TB] FAIL rstmid_fe_count: got %0d expected 0", feTotal - fe0); else passCount++;
    checkCount++; if (frame_len !== 6'd0) $display("[TB] FAIL rstmid_len: got %0d expected 0", frame_len); else passCount++;
    rd_addr = 5'd0; #1;
    checkCount++; if (rd_data !== 8'h00) $display("[TB] FAIL rstmid_rd0: got %h expected 00", rd_data); else passCount++;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_glitch();
    test_stop_error();
    test_pending_ff();
    test_overflow();
    test_max_len();
    test_reset_mid();
    checkCount++; if (bothTotal !== 0) $display("[TB] FAIL valid_err_overlap: got %0d expected 0", bothTotal); else passCount++;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, meaning the RST_clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, meaning the serial bit rate.
REQ-003 The block SHALL have parameter MAX_LEN, default 16, meaning the maximum payload bytes per frame, a power of two up to 32.
REQ-004 The block SHALL have port RST_clk  input  1  the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port RST_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port uart_rx_data  input  1  asynchronous serial line, idle high.
REQ-007 The block SHALL have port rx_byte  output  8  last correctly received byte.
REQ-008 The block SHALL have port rx_byte_valid  output  1  one-cycle pulse when rx_byte updates.
REQ-009 The block SHALL have port rx_busy  output  1  high from validated start bit to end of stop bit.
REQ-010 The block SHALL have port frame_valid  output  1  one-cycle pulse when a complete frame is latched.
REQ-011 The block SHALL have port frame_err  output  1  one-cycle pulse when a frame is discarded.
REQ-012 The block SHALL have port frame_len  output  6  payload length of the last latched frame.
REQ-013 The block SHALL have port rd_addr  input  5  read index into the latched frame.
REQ-014 The block SHALL have port rd_data  output  8  latched payload byte at rd_addr, combinational.

Function
REQ-015 uart_rx_data SHALL pass through a 2-flop synchronizer before any use.
REQ-016 A tick SHALL be generated every CLK_FREQ/(BAUD*16) clocks (integer division, minimum 1) for 16x oversampling.
REQ-017 The receive FSM SHALL have states IDLE, START, DATA, STOP.
REQ-018 IDLE SHALL go to START on a synchronized high-to-low transition and restart the tick count.
REQ-019 START SHALL sample at tick 8 and go to DATA if low, or back to IDLE if high (glitch rejection, no outputs).
REQ-020 DATA SHALL sample 8 bits LSB first, each 16 ticks after the previous sample.
REQ-021 STOP SHALL sample 16 ticks after bit 7.
  - High: rx_byte updates and rx_byte_valid pulses on the next clock, and the FSM returns to IDLE.
  - Low: the byte is dropped, frame_err pulses, the frame assembler clears, and the FSM returns to IDLE.
REQ-022 The frame assembler SHALL treat three consecutive 0xFF bytes as the frame terminator.
REQ-023 Non-0xFF bytes SHALL be appended to the working buffer when no 0xFF is pending.
REQ-024 If one or two pending 0xFF bytes are followed by a non-0xFF byte:
  - frame_err SHALL pulse;
  - the working buffer and pending count SHALL clear;
  - that byte SHALL become byte 0 of a new frame.
REQ-025 On the third 0xFF, the working buffer and its count SHALL copy to the output buffer and frame_len, and frame_valid SHALL pulse one clock after the third rx_byte_valid.
REQ-026 A terminator with zero payload SHALL produce frame_valid with frame_len = 0.
REQ-027 A payload byte arriving when the count equals MAX_LEN SHALL set a drop flag.
  - While the flag is set, bytes SHALL be discarded until the next terminator.
  - That terminator SHALL pulse frame_err instead of frame_valid and clear the flag.
REQ-028 The output buffer and frame_len SHALL change only on frame_valid.
REQ-029 rd_data SHALL be 0x00 for rd_addr >= frame_len.
REQ-030 frame_valid and frame_err SHALL never assert in the same cycle.

Reset
REQ-031 While RST_n is low, the FSM SHALL be IDLE and the tick counter, working buffer, count, pending-0xFF count and drop flag SHALL be zero.
REQ-032 While RST_n is low, the output buffer SHALL be zero and outputs SHALL be rx_byte=0, rx_byte_valid=0, rx_busy=0, frame_valid=0, frame_err=0, frame_len=0.
REQ-033 The synchronizer flops SHALL reset to 1.
REQ-034 Reset asserted mid-byte or mid-frame SHALL abandon all partial data with no pulse.

Verification (CLK_FREQ=1600000, BAUD=100000)
REQ-035 Send 0x71, 0x05, FF FF FF -> rx_byte_valid pulses 5 times, frame_valid pulses once, frame_len=2, rd_data[0]=0x71, rd_data[1]=0x05, rd_data[2]=0x00.
REQ-036 Send a 4-clock low glitch on idle line -> no rx_busy beyond START, no pulses.
REQ-037 Send 0x41 with stop bit low -> frame_err pulse, no rx_byte_valid, rx_byte unchanged.
REQ-038 Send 0x11, FF, FF, 0x22, FF FF FF -> frame_err once, then frame_valid with frame_len=1 and rd_data[0]=0x22.
REQ-039 Send 17 non-FF bytes then FF FF FF (MAX_LEN=16) -> frame_err, no frame_valid, previous frame_len retained.
REQ-040 Assert RST_n low during bit 4 of a byte, release, send FF FF FF -> frame_valid with frame_len=0.
